scan_seq8: RTL and testbench

SCAN_SEQ8 -- requirements
Module: scan_seq8

---
 rtl/scan_seq8.sv | 119 +++++++++++
 tb/tb_scan_seq8.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_seq8.sv
// scan_seq8 -- eight-channel scan sequencer.
//
// A programmable prescaler paces a channel selector that visits the enabled
// channels in turn, ascending or descending. The selector drives the 3-bit
// code {a,b,c} to a downstream 3-to-8 decoder, with a as the MSB.
//
// Ports:
//   clk       sole clock; state updates on the rising edge
//   rst_n     asynchronous, active-low reset
//   en        scan enable; 0 freezes the prescaler and the selection
//   div       dwell period; the selector steps once every div+1 enabled cycles
//   mask      per-channel enable; bit i = 1 means channel i is scanned
//   dir       0 = ascending (0->7), 1 = descending (7->0)
//   load      synchronous load request; has priority over an advance
//   load_sel  channel to load
//   a, b, c   registered channel select, a is the MSB
//   valid     select is an enabled channel and the block is running
//   step      one-cycle pulse, aligned with a select that has just advanced
//   wrap      one-cycle pulse with step when the advance crossed 7/0
module scan_seq8 #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [7:0]       mask,
  input  logic             dir,
  input  logic             load,
  input  logic [2:0]       load_sel,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             valid,
  output logic             step,
  output logic             wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] cnt;
  logic [2:0]       sel;
  logic [2:0]       sel_nx;
  logic [2:0]       cand;
  logic [2:0]       nearest;
  logic             found;
  logic             active;
  logic             tick;
  logic             advance;
  logic             crossed;

  assign {a, b, c} = sel;

  // Nearest enabled channel other than the current one, in scan direction.
  // The loop runs from the farthest distance inwards so that the closest
  // match is the last one written. 3-bit arithmetic wraps modulo 8.
  always_comb begin
    found   = 1'b0;
    nearest = sel;
    cand    = sel;
    for (int i = 7; i >= 1; i--) begin
      cand = dir ? (sel - 3'(i)) : (sel + 3'(i));
      if (mask[cand]) begin
        found   = 1'b1;
        nearest = cand;
      end
    end
  end

  // The prescaler only runs while the block is in RUN and en is still high;
  // >= rather than == means a div lowered below cnt ticks at once.
  assign active  = (state == RUN) && en;
  assign tick    = active && (cnt >= div);
  assign advance = tick && found && !load;
  assign crossed = dir ? (nearest > sel) : (nearest < sel);

  assign state_nx = (en && (mask != 8'h00)) ? RUN : IDLE;

  always_comb begin
    sel_nx = sel;
    if (load) begin
      sel_nx = load_sel;
    end else if (advance) begin
      sel_nx = nearest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 3'b000;
      valid <= 1'b0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      // valid is computed from the next state and select so that it lines up
      // with them and follows a mask change one cycle later.
      valid <= (state_nx == RUN) && mask[sel_nx];
      step  <= advance;
      wrap  <= advance && crossed;
      if (load) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= '0;
      end else if (active) begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_scan_seq8.sv
// tb_scan_seq8 -- self-checking bench for scan_seq8.
//
// A directed vector table covers the basic ascending scan from reset,
// hand-written sequences cover the multi-cycle corner cases (descending
// sparse mask, single channel, load against tick, div change, asynchronous
// reset), and a randomized phase is compared cycle by cycle against a
// behavioural model built from modular arithmetic on channel numbers.
module tb_scan_seq8;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [DIV_W-1:0] div;
  logic [7:0]       mask;
  logic             dir;
  logic             load;
  logic [2:0]       load_sel;
  logic             a;
  logic             b;
  logic             c;
  logic             valid;
  logic             step;
  logic             wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_seq8 #(.DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div      (div),
    .mask     (mask),
    .dir      (dir),
    .load     (load),
    .load_sel (load_sel),
    .a        (a),
    .b        (b),
    .c        (c),
    .valid    (valid),
    .step     (step),
    .wrap     (wrap)
  );

  // Behavioural reference model
  typedef struct {
    bit          run;
    int unsigned cnt;
    int          sel;
    bit          valid;
    bit          step;
    bit          wrap;
  } mstate_t;

  mstate_t m;

  // Closest enabled channel at distance 1..7 in the scan direction, or -1.
  function automatic int nearest_channel(int cur, bit [7:0] msk, bit down);
    for (int d = 1; d < 8; d++) begin
      int k;
      k = down ? ((cur - d + 8) % 8) : ((cur + d) % 8);
      if (msk[k]) return k;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit en_i, int unsigned div_i,
                                         bit [7:0] mask_i, bit dir_i, bit load_i,
                                         int ld_sel);
    mstate_t n;
    int      k;
    n      = s;
    n.step = 1'b0;
    n.wrap = 1'b0;
    if (load_i) begin
      n.sel = ld_sel;
      n.cnt = 0;
    end else if (s.run && en_i) begin
      if (s.cnt >= div_i) begin
        n.cnt = 0;
        k = nearest_channel(s.sel, mask_i, dir_i);
        if (k >= 0) begin
          n.sel  = k;
          n.step = 1'b1;
          n.wrap = dir_i ? (k > s.sel) : (k < s.sel);
        end
      end else begin
        n.cnt = s.cnt + 1;
      end
    end
    n.run   = en_i && (mask_i != 8'h00);
    n.valid = n.run && mask_i[n.sel];
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{default: 0};
    end else begin
      m <= model_next(m, en, div, mask, dir, load, int'(load_sel));
    end
  end

  // Checking helpers
  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares {sel,valid,step,wrap} against the reference model.
  task automatic checkOutput(string name);
    check_val(name, {26'd0, a, b, c, valid, step, wrap},
              {26'd0, 3'(m.sel), m.valid, m.step, m.wrap});
  endtask

  task automatic applyStimulus(bit e, int unsigned d, bit [7:0] mk, bit dr,
                               bit ld, bit [2:0] ls);
    en       = e;
    div      = DIV_W'(d);
    mask     = mk;
    dir      = dr;
    load     = ld;
    load_sel = ls;
  endtask

  task automatic next_cycle(string name);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  // Drops rst_n between edges, checks the asynchronous clear, releases.
  task automatic pulse_reset(string name);
    #2;
    rst_n = 1'b0;
    #1;
    check_val({name, "_async_clear"}, {26'd0, a, b, c, valid, step, wrap}, 32'd0);
    checkOutput({name, "_model"});
    #1;
    rst_n = 1'b1;
  endtask

  // Directed vector table
  typedef struct {
    bit          e;
    int unsigned d;
    bit [7:0]    mk;
    bit          dr;
    bit [2:0]    exp_sel;
    bit          exp_valid;
    bit          exp_step;
    bit          exp_wrap;
  } vec_t;

  vec_t tbl[26];

  initial begin
    // Ascending full scan with div=2: edge n after release shows channel
    // ((n-1)/3) mod 8, a step every third edge, wrap on the return to 0.
    for (int i = 0; i < 26; i++) begin
      int n;
      int s;
      bit st;
      n  = i + 1;
      s  = ((n - 1) / 3) % 8;
      st = (n > 1) && (((n - 1) % 3) == 0);
      tbl[i] = '{1'b1, 2, 8'hFF, 1'b0, 3'(s), 1'b1, st, st && (s == 0)};
    end

    rst_n = 1'b0;
    applyStimulus(1'b1, 2, 8'hFF, 1'b0, 1'b0, 3'd0);
    #2;
    check_val("reset_outputs", {26'd0, a, b, c, valid, step, wrap}, 32'd0);
    #6;
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      applyStimulus(tbl[i].e, tbl[i].d, tbl[i].mk, tbl[i].dr, 1'b0, 3'd0);
      next_cycle("tbl_model");
      check_val($sformatf("tbl_sel_%0d", i), {29'd0, a, b, c}, {29'd0, tbl[i].exp_sel});
      check_val($sformatf("tbl_flags_%0d", i), {29'd0, valid, step, wrap},
                {29'd0, tbl[i].exp_valid, tbl[i].exp_step, tbl[i].exp_wrap});
    end

    // Descending over channels 7,5,2 starting from 5: 5->2->7->5.
    applyStimulus(1'b1, 0, 8'b1010_0100, 1'b1, 1'b1, 3'd5);
    next_cycle("desc_load");
    check_val("desc_start", {29'd0, a, b, c}, 32'd5);
    applyStimulus(1'b1, 0, 8'b1010_0100, 1'b1, 1'b0, 3'd0);
    next_cycle("desc_1");
    check_val("desc_1_sel_step_wrap", {26'd0, a, b, c, valid, step, wrap}, {26'd0, 3'd2, 3'b110});
    next_cycle("desc_2");
    check_val("desc_2_sel_step_wrap", {26'd0, a, b, c, valid, step, wrap}, {26'd0, 3'd7, 3'b111});
    next_cycle("desc_3");
    check_val("desc_3_sel_step_wrap", {26'd0, a, b, c, valid, step, wrap}, {26'd0, 3'd5, 3'b110});

    // Single enabled channel: ticks never move the select.
    applyStimulus(1'b1, 0, 8'h10, 1'b0, 1'b1, 3'd4);
    next_cycle("single_load");
    applyStimulus(1'b1, 0, 8'h10, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle("single_hold");
      check_val("single_hold", {26'd0, a, b, c, valid, step, wrap}, {26'd0, 3'd4, 3'b100});
    end
    applyStimulus(1'b1, 0, 8'h00, 1'b0, 1'b0, 3'd0);
    next_cycle("mask_zero");
    check_val("mask_zero_valid", {31'd0, valid}, 32'd0);
    next_cycle("idle_hold");
    check_val("idle_hold_sel", {29'd0, a, b, c}, 32'd4);

    // Load of a masked channel coincident with a tick.
    applyStimulus(1'b1, 1, 8'hBF, 1'b0, 1'b1, 3'd0);
    next_cycle("ld_prep");
    applyStimulus(1'b1, 1, 8'hBF, 1'b0, 1'b0, 3'd0);
    next_cycle("ld_count");
    applyStimulus(1'b1, 1, 8'hBF, 1'b0, 1'b1, 3'd6);
    next_cycle("ld_tick");
    check_val("ld_tick_out", {26'd0, a, b, c, valid, step, wrap}, {26'd0, 3'd6, 3'b000});
    applyStimulus(1'b1, 1, 8'hBF, 1'b0, 1'b0, 3'd0);
    next_cycle("ld_wait");
    check_val("ld_wait_out", {26'd0, a, b, c, valid, step, wrap}, {26'd0, 3'd6, 3'b000});
    next_cycle("ld_adv");
    check_val("ld_adv_out", {26'd0, a, b, c, valid, step, wrap}, {26'd0, 3'd7, 3'b110});

    // div lowered from 9 to 3 while cnt=7: immediate tick, then 4-cycle dwell.
    applyStimulus(1'b1, 9, 8'hFF, 1'b0, 1'b1, 3'd0);
    next_cycle("div_load");
    applyStimulus(1'b1, 9, 8'hFF, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 7; i++) begin
      next_cycle("div_count");
      check_val("div_count_step", {31'd0, step}, 32'd0);
    end
    applyStimulus(1'b1, 3, 8'hFF, 1'b0, 1'b0, 3'd0);
    next_cycle("div_drop");
    check_val("div_drop_tick", {28'd0, a, b, c, step}, {28'd0, 3'd1, 1'b1});
    for (int k = 1; k <= 8; k++) begin
      next_cycle("div_dwell");
      check_val($sformatf("div_dwell_%0d", k), {31'd0, step}, {31'd0, (k % 4) == 0});
    end

    // Asynchronous reset mid-scan, then a full div+1 RUN cycles to the first step.
    applyStimulus(1'b1, 2, 8'hFF, 1'b0, 1'b0, 3'd0);
    next_cycle("pre_reset");
    pulse_reset("mid_scan");
    for (int n = 1; n <= 4; n++) begin
      next_cycle("post_reset");
      check_val($sformatf("post_reset_%0d", n), {28'd0, a, b, c, step},
                {28'd0, (n == 4) ? 3'd1 : 3'd0, n == 4});
    end

    // Randomized phase against the model.
    applyStimulus(1'b1, 1, 8'hFF, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 600; i++) begin
      next_cycle("rand");
      if ($urandom_range(0, 99) == 0) pulse_reset("rand");
      en   = ($urandom_range(0, 9) != 0);
      div  = DIV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      load     = ($urandom_range(0, 15) == 0);
      load_sel = 3'($urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
